// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INC    = 4;

endpackage : fetch_pkg

// File: rtl/fetch_ctrl_next_pc_sel.sv
// Combinational next-PC / next-fetch-address selection for fetch_ctrl,
// including redirect-target word alignment and misalignment detection.
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  fetch_state_t     state,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] addr_q,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             imem_ack,
  input  logic             stall,
  input  logic             instr_valid,
  output logic             accept,
  output logic             drop_held,
  output logic             fault,
  output logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] addr_next
);

  logic [WIDTH-1:0] target_aligned;
  logic [WIDTH-1:0] seq_addr;
  logic             req_ack;

  // Redirect targets are forced onto a word boundary.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_align
      if (gi < 2) begin : g_low
        assign target_aligned[gi] = 1'b0;
      end else begin : g_high
        assign target_aligned[gi] = redirect_target[gi];
      end
    end
  endgenerate

  assign seq_addr = addr_q + WIDTH'(PC_INC);
  assign req_ack  = (state == REQ) && imem_ack && !redirect;

  // A returning word may only replace the output register if decode has
  // consumed it (or it is empty); otherwise the word is refetched later.
  assign accept    = req_ack && (!instr_valid || !stall);
  assign drop_held = req_ack && instr_valid && stall;

  assign fault = redirect && (state != IDLE) && (redirect_target[1:0] != 2'b00);

  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = target_aligned;
    end else if (accept) begin
      pc_next = seq_addr;
    end
  end

  // addr_q only reloads when a fresh request is about to start, so the
  // address stays stable for as long as imem_req is held.
  always_comb begin
    addr_next = addr_q;
    case (state)
      IDLE: begin
        addr_next = pc_next;
      end
      REQ: begin
        if (redirect ? imem_ack : accept) begin
          addr_next = pc_next;
        end
      end
      HOLD: begin
        if (redirect || !stall) begin
          addr_next = pc_next;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          addr_next = pc_next;
        end
      end
      default: addr_next = addr_q;
    endcase
  end

endmodule : next_pc_sel

// File: rtl/fetch_ctrl.sv
// Front-end fetch controller: owns the fetch PC, runs a single-outstanding
// instruction-memory handshake and presents a registered instr/pc to decode.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               INSTR_W      = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [WIDTH-1:0]   redirect_target,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [WIDTH-1:0]   instr_pc,
  output logic               fetch_fault
);

  fetch_state_t       state_reg, state_next;
  logic [WIDTH-1:0]   pc_reg, pc_next;
  logic [WIDTH-1:0]   addr_q_reg, addr_next;
  logic               instr_valid_reg, instr_valid_next;
  logic [INSTR_W-1:0] instr_reg, instr_next;
  logic [WIDTH-1:0]   instr_pc_reg, instr_pc_next;
  logic               fault_reg, fault_next;
  logic               accept, drop_held;

  next_pc_sel #(
    .WIDTH (WIDTH)
  ) u_next_pc_sel (
    .state           (state_reg),
    .pc              (pc_reg),
    .addr_q          (addr_q_reg),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_ack        (imem_ack),
    .stall           (stall),
    .instr_valid     (instr_valid_reg),
    .accept          (accept),
    .drop_held       (drop_held),
    .fault           (fault_next),
    .pc_next         (pc_next),
    .addr_next       (addr_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_VECTOR;
      addr_q_reg      <= RESET_VECTOR;
      instr_valid_reg <= 1'b0;
      instr_reg       <= INSTR_W'(NOP_INSTR);
      instr_pc_reg    <= '0;
      fault_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      addr_q_reg      <= addr_next;
      instr_valid_reg <= instr_valid_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
      fault_reg       <= fault_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    instr_valid_next = instr_valid_reg;
    instr_next       = instr_reg;
    instr_pc_next    = instr_pc_reg;

    case (state_reg)
      IDLE: begin
        state_next = REQ;
      end

      REQ: begin
        if (redirect) begin
          instr_valid_next = 1'b0;
          instr_next       = INSTR_W'(NOP_INSTR);
          state_next       = imem_ack ? REQ : DISCARD;
        end else if (accept) begin
          instr_valid_next = 1'b1;
          instr_next       = imem_rdata;
          instr_pc_next    = addr_q_reg;
          state_next       = REQ;
        end else if (drop_held) begin
          // Held word is still unconsumed; pc still points at addr_q,
          // so the dropped word is refetched once the stall clears.
          state_next = HOLD;
        end else if (instr_valid_reg && !stall) begin
          instr_valid_next = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          instr_valid_next = 1'b0;
          instr_next       = INSTR_W'(NOP_INSTR);
          state_next       = REQ;
        end else if (!stall) begin
          instr_valid_next = 1'b0;
          state_next       = REQ;
        end
      end

      DISCARD: begin
        if (redirect) begin
          instr_valid_next = 1'b0;
          instr_next       = INSTR_W'(NOP_INSTR);
        end
        if (imem_ack) begin
          state_next = REQ;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign imem_req    = (state_reg == REQ) || (state_reg == DISCARD);
  assign imem_addr   = addr_q_reg;
  assign instr_valid = instr_valid_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign fetch_fault = fault_reg;

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a combinational memory
// whose returned word is the address XOR a fixed tag.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] MAGIC = 32'h5A00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ MAGIC;

  fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .fetch_fault     (fetch_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_ipc",   instr_pc, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);

    // Release reset with a zero-wait memory.
    rst = 1'b1; imem_ack = 1'b1;
    step();  // IDLE -> REQ
    chk("e1_req",   32'(imem_req), 32'd1);
    chk("e1_addr",  imem_addr, 32'h0);
    chk("e1_valid", 32'(instr_valid), 32'd0);
    step();
    chk("e2_valid", 32'(instr_valid), 32'd1);
    chk("e2_ipc",   instr_pc, 32'h0);
    chk("e2_instr", instr, 32'h0 ^ MAGIC);
    chk("e2_addr",  imem_addr, 32'h4);
    step();
    chk("e3_addr",  imem_addr, 32'h8);
    chk("e3_ipc",   instr_pc, 32'h4);
    step();
    chk("e4_addr",  imem_addr, 32'hC);
    chk("e4_ipc",   instr_pc, 32'h8);

    // Stall four cycles while instr_pc=0x8 is held.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("hold%0d_req", i),   32'(imem_req), 32'd0);
      chk($sformatf("hold%0d_ipc", i),   instr_pc, 32'h8);
      chk($sformatf("hold%0d_instr", i), instr, 32'h8 ^ MAGIC);
      chk($sformatf("hold%0d_valid", i), 32'(instr_valid), 32'd1);
    end
    stall = 1'b0;
    step();
    chk("unstall_req",   32'(imem_req), 32'd1);
    chk("unstall_addr",  imem_addr, 32'hC);
    chk("unstall_valid", 32'(instr_valid), 32'd0);
    step();
    chk("refetch_ipc",  instr_pc, 32'hC);
    chk("refetch_addr", imem_addr, 32'h10);

    // Memory wait states on 0x10.
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("wait%0d_req", i),   32'(imem_req), 32'd1);
      chk($sformatf("wait%0d_addr", i),  imem_addr, 32'h10);
      chk($sformatf("wait%0d_valid", i), 32'(instr_valid), 32'd0);
    end
    imem_ack = 1'b1;
    step();
    chk("late_ipc",   instr_pc, 32'h10);
    chk("late_instr", instr, 32'h10 ^ MAGIC);
    chk("late_valid", 32'(instr_valid), 32'd1);
    step();
    step();
    step();
    chk("run_addr", imem_addr, 32'h20);
    chk("run_ipc",  instr_pc, 32'h1C);

    // Redirect while the 0x20 request is outstanding.
    imem_ack = 1'b0;
    step();
    chk("out_addr", imem_addr, 32'h20);
    redirect = 1'b1; redirect_target = 32'h100;
    step();
    chk("disc_req",   32'(imem_req), 32'd1);
    chk("disc_addr",  imem_addr, 32'h20);
    chk("disc_valid", 32'(instr_valid), 32'd0);
    chk("disc_instr", instr, NOP);
    chk("disc_fault", 32'(fetch_fault), 32'd0);
    redirect = 1'b0;
    step();
    chk("disc2_addr", imem_addr, 32'h20);
    imem_ack = 1'b1;
    step();
    chk("drop_addr",  imem_addr, 32'h100);
    chk("drop_valid", 32'(instr_valid), 32'd0);
    chk("drop_instr", instr, NOP);
    step();
    chk("tgt_ipc",   instr_pc, 32'h100);
    chk("tgt_instr", instr, 32'h100 ^ MAGIC);
    chk("tgt_addr",  imem_addr, 32'h104);

    // Misaligned redirect target.
    redirect = 1'b1; redirect_target = 32'h102;
    step();
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_addr",  imem_addr, 32'h100);
    chk("mis_valid", 32'(instr_valid), 32'd0);
    redirect = 1'b0;
    step();
    chk("mis_fault_off", 32'(fetch_fault), 32'd0);
    chk("mis_ipc",       instr_pc, 32'h100);

    // Address wrap at the top of the space.
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    step();
    chk("wrap_ipc",  instr_pc, 32'hFFFF_FFFC);
    chk("wrap_next", imem_addr, 32'h0);

    // Asynchronous reset in the middle of a request.
    imem_ack = 1'b0;
    #2;
    chk("pre_arst_req", 32'(imem_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_req",   32'(imem_req), 32'd0);
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_instr", instr, NOP);
    chk("arst_addr",  imem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_ctrl
